// File: rtl/instruction_loader_if.sv
// Byte-stream / instruction-RAM write bundle for instruction_loader.
//   master: stream source (drives start, byte_data, byte_valid) and observer of the outputs.
//   slave : the loader itself.
// Signals:
//   start         one-cycle session start pulse
//   byte_data     stream byte
//   byte_valid    byte_data valid this cycle
//   byte_ready    loader consumes a byte this cycle when byte_valid is also high
//   write_enable  one-cycle instruction RAM write strobe
//   write_address RAM write address
//   write_data    RAM write data (packed instruction)
//   cpu_reset     active-high CPU hold
//   busy          session in progress
//   done          one-cycle pulse on a successful session
//   error         sticky error flag, cleared by the next accepted start
//   word_count    word count from the current or last header
interface instruction_loader_if #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned INSTR_WIDTH = 28
);
  logic                   start;
  logic [7:0]             byte_data;
  logic                   byte_valid;
  logic                   byte_ready;
  logic                   write_enable;
  logic [ADDR_WIDTH-1:0]  write_address;
  logic [INSTR_WIDTH-1:0] write_data;
  logic                   cpu_reset;
  logic                   busy;
  logic                   done;
  logic                   error;
  logic [15:0]            word_count;

  modport master (
    output start, byte_data, byte_valid,
    input  byte_ready, write_enable, write_address, write_data,
    input  cpu_reset, busy, done, error, word_count
  );

  modport slave (
    input  start, byte_data, byte_valid,
    output byte_ready, write_enable, write_address, write_data,
    output cpu_reset, busy, done, error, word_count
  );
endinterface

// File: rtl/instruction_loader.sv
// Loads a program into the writable instruction RAM from a framed byte stream while holding
// the CPU in reset. Frame: 16-bit big-endian word count, 4 bytes per instruction (top nibble
// of the first byte must be zero), then one XOR checksum byte over everything since start.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    instruction_loader_if slave (stream in, RAM write strobe and status out)
// INSTR_WIDTH must lie in 17..32.
module instruction_loader #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned INSTR_WIDTH = 28,
  parameter int unsigned MAX_WORDS   = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instruction_loader_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StLenHi, StLenLo, StData, StCheck, StDone} state_e;

  localparam logic [15:0]           MaxWords = 16'(MAX_WORDS);
  localparam logic [ADDR_WIDTH-1:0] AddrOne  = ADDR_WIDTH'(1);
  localparam int unsigned           ShiftW   = INSTR_WIDTH - 8;

  state_e                 state_q, state_d;
  logic [15:0]            count_q, count_d;
  logic [15:0]            words_q, words_d;
  logic [7:0]             csum_q, csum_d;
  logic [1:0]             idx_q, idx_d;
  // Only the bytes that survive into the instruction are kept; byte 0's top nibble is
  // checked to be zero and then falls off the top.
  logic [ShiftW-1:0]      shift_q, shift_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   we_q, we_d;
  logic [ADDR_WIDTH-1:0]  waddr_q, waddr_d;
  logic [INSTR_WIDTH-1:0] wdata_q, wdata_d;
  logic                   err_q, err_d;
  logic                   cpu_q, cpu_d;

  logic        accept;
  logic [15:0] words_inc;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    words_d   = words_q;
    csum_d    = csum_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    cpu_d     = cpu_q;
    words_inc = words_q + 16'd1;

    bus.byte_ready = (state_q == StLenHi) || (state_q == StLenLo) ||
                     (state_q == StData)  || (state_q == StCheck);
    accept = bus.byte_valid && bus.byte_ready;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          err_d   = 1'b0;
          csum_d  = 8'h00;
          idx_d   = 2'd0;
          addr_d  = '0;
          words_d = 16'd0;
          cpu_d   = 1'b1;
          state_d = StLenHi;
        end
      end
      StLenHi: begin
        if (accept) begin
          count_d = {bus.byte_data, count_q[7:0]};
          csum_d  = csum_q ^ bus.byte_data;
          state_d = StLenLo;
        end
      end
      StLenLo: begin
        if (accept) begin
          count_d = {count_q[15:8], bus.byte_data};
          csum_d  = csum_q ^ bus.byte_data;
          if (count_d > MaxWords) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else if (count_d == 16'd0) begin
            state_d = StCheck;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          csum_d = csum_q ^ bus.byte_data;
          if ((idx_q == 2'd0) && (bus.byte_data[7:4] != 4'h0)) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else if (idx_q == 2'd3) begin
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = {shift_q, bus.byte_data};
            addr_d  = addr_q + AddrOne;
            words_d = words_inc;
            idx_d   = 2'd0;
            if (words_inc == count_q) state_d = StCheck;
          end else begin
            shift_d = {shift_q[ShiftW-9:0], bus.byte_data};
            idx_d   = idx_q + 2'd1;
          end
        end
      end
      StCheck: begin
        if (accept) begin
          if (bus.byte_data == csum_q) begin
            state_d = StDone;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StDone: begin
        cpu_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= 16'd0;
      words_q <= 16'd0;
      csum_q  <= 8'h00;
      idx_q   <= 2'd0;
      shift_q <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      cpu_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      words_q <= words_d;
      csum_q  <= csum_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      cpu_q   <= cpu_d;
    end
  end

  assign bus.write_enable  = we_q;
  assign bus.write_address = waddr_q;
  assign bus.write_data    = wdata_q;
  assign bus.cpu_reset     = cpu_q;
  assign bus.busy          = (state_q != StIdle);
  assign bus.done          = (state_q == StDone);
  assign bus.error         = err_q;
  assign bus.word_count    = count_q;

endmodule

// File: tb/tb_instruction_loader.sv
module tb_instruction_loader;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;
  int   wr_cnt;
  int   done_cnt;
  logic [15:0] wq_addr [$];
  logic [27:0] wq_data [$];
  logic [7:0]  stim [$];

  instruction_loader_if #(.ADDR_WIDTH(16), .INSTR_WIDTH(28)) bus ();

  instruction_loader #(.ADDR_WIDTH(16), .INSTR_WIDTH(28), .MAX_WORDS(256)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.write_enable === 1'b1) begin
      wr_cnt++;
      wq_addr.push_back(bus.write_address);
      wq_data.push_back(bus.write_data);
    end
    if (bus.done === 1'b1) done_cnt++;
  end

  // Called at #1 after an edge; returns at #1 after the edge that consumed the byte.
  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    bus.byte_data  = b;
    bus.byte_valid = 1'b1;
    while (bus.byte_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    total_cnt++;
    if (bus.byte_ready !== 1'b1) begin
      $display("FAIL byte_accept: byte %h not accepted, ready=%b required 1", b, bus.byte_ready);
    end else begin
      pass_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic idle_cycles(input int n);
    bus.byte_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Sends stim with random gaps of 0..max_gap idle cycles; pulses start before byte start_at.
  task automatic send_stim(input int max_gap, input int start_at);
    for (int i = 0; i < stim.size(); i++) begin
      if (max_gap > 0) idle_cycles($urandom_range(max_gap, 0));
      if (i == start_at) begin
        bus.byte_valid = 1'b0;
        pulse_start();
        total_cnt++;
        if (bus.busy !== 1'b1 || bus.word_count !== 16'd2) begin
          $display("FAIL start_ignored: busy=%b count=%h required 1 0002", bus.busy,
                   bus.word_count);
        end else pass_cnt++;
      end
      send_byte(stim[i]);
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.byte_data = 8'hAB;
    bus.byte_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({bus.byte_ready, bus.write_enable, bus.cpu_reset, bus.busy, bus.done, bus.error}
        !== 6'b0) begin
      $display("FAIL reset_flags: rdy/we/cpu/busy/done/err=%b required 000000",
               {bus.byte_ready, bus.write_enable, bus.cpu_reset, bus.busy, bus.done, bus.error});
    end else pass_cnt++;
    total_cnt++;
    if (bus.write_address !== 16'd0 || bus.write_data !== 28'd0 || bus.word_count !== 16'd0) begin
      $display("FAIL reset_values: addr=%h data=%h count=%h required 0 0 0", bus.write_address,
               bus.write_data, bus.word_count);
    end else pass_cnt++;
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    total_cnt++;
    if (bus.byte_ready !== 1'b0 || wr_cnt !== 0 || bus.busy !== 1'b0) begin
      $display("FAIL idle_not_ready: ready=%b writes=%0d busy=%b required 0 0 0",
               bus.byte_ready, wr_cnt, bus.busy);
    end else pass_cnt++;
    bus.byte_valid = 1'b0;
  endtask

  task automatic test_good_load();
    int w0;
    w0 = wr_cnt;
    pulse_start();
    total_cnt++;
    if ({bus.busy, bus.cpu_reset, bus.byte_ready} !== 3'b111) begin
      $display("FAIL start_response: busy/cpu/ready=%b required 111",
               {bus.busy, bus.cpu_reset, bus.byte_ready});
    end else pass_cnt++;
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h0A); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    total_cnt++;
    if (bus.write_enable !== 1'b1 || bus.write_address !== 16'd0 ||
        bus.write_data !== 28'hA123456) begin
      $display("FAIL write0: we=%b addr=%h data=%h required 1 0000 a123456", bus.write_enable,
               bus.write_address, bus.write_data);
    end else pass_cnt++;
    send_byte(8'h01);
    total_cnt++;
    if (bus.write_enable !== 1'b0) begin
      $display("FAIL write_pulse_width: we=%b required 0", bus.write_enable);
    end else pass_cnt++;
    send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    total_cnt++;
    if (bus.write_enable !== 1'b1 || bus.write_address !== 16'd1 ||
        bus.write_data !== 28'h1020304) begin
      $display("FAIL write1: we=%b addr=%h data=%h required 1 0001 1020304", bus.write_enable,
               bus.write_address, bus.write_data);
    end else pass_cnt++;
    send_byte(8'h7C);
    bus.byte_valid = 1'b0;
    total_cnt++;
    if ({bus.done, bus.cpu_reset, bus.busy, bus.error} !== 4'b1110) begin
      $display("FAIL checksum_done: done/cpu/busy/err=%b required 1110",
               {bus.done, bus.cpu_reset, bus.busy, bus.error});
    end else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if ({bus.done, bus.cpu_reset, bus.busy} !== 3'b000 || bus.word_count !== 16'd2 ||
        wr_cnt - w0 !== 2) begin
      $display("FAIL release: done/cpu/busy=%b count=%h writes=%0d required 000 0002 2",
               {bus.done, bus.cpu_reset, bus.busy}, bus.word_count, wr_cnt - w0);
    end else pass_cnt++;
  endtask

  task automatic test_bad_checksum();
    int w0;
    int d0;
    w0 = wr_cnt;
    d0 = done_cnt;
    pulse_start();
    stim = '{8'h00, 8'h02, 8'h0A, 8'h12, 8'h34, 8'h56, 8'h01, 8'h02, 8'h03, 8'h04, 8'h7D};
    send_stim(0, -1);
    total_cnt++;
    if ({bus.error, bus.busy, bus.done, bus.cpu_reset} !== 4'b1001) begin
      $display("FAIL bad_checksum: err/busy/done/cpu=%b required 1001",
               {bus.error, bus.busy, bus.done, bus.cpu_reset});
    end else pass_cnt++;
    idle_cycles(4);
    total_cnt++;
    if (bus.cpu_reset !== 1'b1 || bus.error !== 1'b1 || done_cnt !== d0 || wr_cnt - w0 !== 2) begin
      $display("FAIL error_sticky: cpu=%b err=%b dones=%0d writes=%0d required 1 1 %0d 2",
               bus.cpu_reset, bus.error, done_cnt - d0, wr_cnt - w0, 0);
    end else pass_cnt++;
    pulse_start();
    total_cnt++;
    if (bus.error !== 1'b0 || bus.cpu_reset !== 1'b1) begin
      $display("FAIL start_clears_error: err=%b cpu=%b required 0 1", bus.error, bus.cpu_reset);
    end else pass_cnt++;
    stim = '{8'h00, 8'h02, 8'h0A, 8'h12, 8'h34, 8'h56, 8'h01, 8'h02, 8'h03, 8'h04, 8'h7C};
    send_stim(0, -1);
    idle_cycles(2);
    total_cnt++;
    if (bus.cpu_reset !== 1'b0 || bus.error !== 1'b0 || done_cnt - d0 !== 1) begin
      $display("FAIL recovery: cpu=%b err=%b dones=%0d required 0 0 1", bus.cpu_reset,
               bus.error, done_cnt - d0);
    end else pass_cnt++;
  endtask

  task automatic test_bad_nibble();
    int w0;
    w0 = wr_cnt;
    pulse_start();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h1A);
    total_cnt++;
    if ({bus.error, bus.byte_ready, bus.busy} !== 3'b100 || bus.word_count !== 16'd1) begin
      $display("FAIL bad_nibble: err/ready/busy=%b count=%h required 100 0001",
               {bus.error, bus.byte_ready, bus.busy}, bus.word_count);
    end else pass_cnt++;
    bus.byte_data = 8'h12;
    repeat (3) begin @(posedge clk); #1; end
    bus.byte_valid = 1'b0;
    total_cnt++;
    if (bus.byte_ready !== 1'b0 || wr_cnt !== w0 || bus.cpu_reset !== 1'b1) begin
      $display("FAIL nibble_no_consume: ready=%b writes=%0d cpu=%b required 0 0 1",
               bus.byte_ready, wr_cnt - w0, bus.cpu_reset);
    end else pass_cnt++;
  endtask

  task automatic test_zero_and_oversize();
    int w0;
    w0 = wr_cnt;
    pulse_start();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    bus.byte_valid = 1'b0;
    total_cnt++;
    if (bus.done !== 1'b1 || bus.error !== 1'b0 || bus.word_count !== 16'd0 || wr_cnt !== w0) begin
      $display("FAIL zero_words: done=%b err=%b count=%h writes=%0d required 1 0 0000 0",
               bus.done, bus.error, bus.word_count, wr_cnt - w0);
    end else pass_cnt++;
    idle_cycles(2);
    pulse_start();
    send_byte(8'h01); send_byte(8'h01);
    bus.byte_valid = 1'b0;
    total_cnt++;
    if ({bus.error, bus.busy, bus.byte_ready} !== 3'b100 || bus.word_count !== 16'h0101) begin
      $display("FAIL oversize: err/busy/ready=%b count=%h required 100 0101",
               {bus.error, bus.busy, bus.byte_ready}, bus.word_count);
    end else pass_cnt++;
    idle_cycles(2);
  endtask

  task automatic test_gaps_and_reset();
    int d0;
    d0 = done_cnt;
    wq_addr.delete();
    wq_data.delete();
    pulse_start();
    stim = '{8'h00, 8'h02, 8'h0A, 8'h12, 8'h34, 8'h56, 8'h01, 8'h02, 8'h03, 8'h04, 8'h7C};
    send_stim(5, 5);
    idle_cycles(2);
    total_cnt++;
    if (wq_addr.size() !== 2 || done_cnt - d0 !== 1 || bus.error !== 1'b0 ||
        bus.cpu_reset !== 1'b0) begin
      $display("FAIL gapped_session: writes=%0d dones=%0d err=%b cpu=%b required 2 1 0 0",
               wq_addr.size(), done_cnt - d0, bus.error, bus.cpu_reset);
    end else pass_cnt++;
    total_cnt++;
    if (wq_addr.size() < 2 || wq_data[0] !== 28'hA123456 || wq_data[1] !== 28'h1020304 ||
        wq_addr[0] !== 16'd0 || wq_addr[1] !== 16'd1) begin
      $display("FAIL gapped_data: got %0d writes required 0:a123456 1:1020304", wq_addr.size());
    end else pass_cnt++;
    pulse_start();
    send_byte(8'h00); send_byte(8'h02); send_byte(8'h0A); send_byte(8'h12); send_byte(8'h34);
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({bus.byte_ready, bus.write_enable, bus.cpu_reset, bus.busy, bus.done, bus.error}
        !== 6'b0 || bus.word_count !== 16'd0 || bus.write_address !== 16'd0 ||
        bus.write_data !== 28'd0) begin
      $display("FAIL async_reset: flags=%b count=%h addr=%h data=%h required 0 0 0 0",
               {bus.byte_ready, bus.write_enable, bus.cpu_reset, bus.busy, bus.done, bus.error},
               bus.word_count, bus.write_address, bus.write_data);
    end else pass_cnt++;
    bus.byte_valid = 1'b0;
    rst_n = 1'b1;
    idle_cycles(2);
    wq_addr.delete();
    wq_data.delete();
    pulse_start();
    send_stim(0, -1);
    idle_cycles(2);
    total_cnt++;
    if (wq_addr.size() !== 2 || bus.cpu_reset !== 1'b0 || bus.error !== 1'b0) begin
      $display("FAIL reload_after_reset: writes=%0d cpu=%b err=%b required 2 0 0",
               wq_addr.size(), bus.cpu_reset, bus.error);
    end else pass_cnt++;
    total_cnt++;
    if (wq_addr.size() < 2 || wq_addr[0] !== 16'd0 || wq_data[0] !== 28'hA123456 ||
        wq_addr[1] !== 16'd1 || wq_data[1] !== 28'h1020304) begin
      $display("FAIL reload_data: got %0d writes required 0:a123456 1:1020304", wq_addr.size());
    end else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    wr_cnt = 0;
    done_cnt = 0;
    bus.start = 1'b0;
    bus.byte_data = 8'h00;
    bus.byte_valid = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_bad_nibble();
    test_zero_and_oversize();
    test_gaps_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Loads a program into the CPU's writable instruction memory from a byte stream, such as a keyboard or serial front end, while holding the CPU in reset. It is the write-side counterpart of the instruction fetch path. The loader parses a framed session: a 16-bit word count, a 28-bit instruction packed in each 4-byte group, and an XOR checksum. It then emits one-cycle write strobes into the instruction RAM that the CPU fetches from with its 16-bit address / 28-bit instruction interface.

## Interface
- ADDR_WIDTH, 16, instruction memory address width
- INSTR_WIDTH, 28, instruction width (`{opcode, dest, src1, src0}` packed format)
- MAX_WORDS, 256, largest accepted word count
- Clock  in  1  single clock; all logic on rising edge
- Reset  in  1  asynchronous, active-low; clears all state
- iStart  in  1  one-cycle pulse; starts a session; honoured only in IDLE
- iByte  in  8  stream data
- iByteValid  in  1  iByte valid this cycle
- oByteReady  out  1  loader accepts a byte this cycle; transfer happens when iByteValid && oByteReady
- oWriteEnable  out  1  one-cycle instruction RAM write strobe
- oWriteAddress  out  ADDR_WIDTH  write address
- oWriteData  out  INSTR_WIDTH  write data
- oCpuReset  out  1  active-high hold of the CPU
- oBusy  out  1  session in progress
- oDone  out  1  one-cycle pulse on successful completion
- oError  out  1  sticky; cleared by the next accepted iStart
- oWordCount  out  16  word count latched from the current or last header

## Operation
- States: IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE.
- IDLE:
  - iStart clears oError, the checksum register, the byte index and the word address.
  - It sets oCpuReset and oBusy, then moves to LEN_HI.
- LEN_HI / LEN_LO:
  - Accept the count N, big-endian, into oWordCount.
  - After LEN_LO:
    - N > MAX_WORDS → error.
    - N = 0 → CHECK.
    - Otherwise → DATA.
- DATA:
  - Bytes are assembled big-endian into 32 bits. Byte index 0..3 wraps to 0.
  - Byte 0 bits [7:4] must be 0; otherwise → error immediately. No write occurs for that word.
  - When byte 3 is accepted, the lower 28 bits are registered with the current address. The address increments by 1.
  - After word N-1 → CHECK.
- CHECK:
  - Accept one byte and compare it with the running XOR of every byte accepted since iStart, including both length bytes.
  - Equal → DONE. Otherwise → error.
- DONE:
  - oDone = 1 for one cycle.
  - oCpuReset and oBusy drop, then the loader returns to IDLE.
- Error path:
  - Sets oError and returns to IDLE with oBusy = 0.
  - oCpuReset stays 1 until the next successful session, so the CPU never runs a partially loaded program.
- oByteReady = 1 only in LEN_HI, LEN_LO, DATA and CHECK. Bytes presented in any other state are not consumed.
- iStart while oBusy is ignored.
- iByteValid may drop for any number of cycles between bytes. Gaps never change state.

## Timing
- Reset values:
  - state IDLE
  - oByteReady, oWriteEnable, oCpuReset, oBusy, oDone, oError = 0
  - oWriteAddress, oWriteData, oWordCount = 0
- iStart in cycle t → oBusy, oCpuReset and oByteReady = 1 at t+1.
- Byte 3 of a word accepted at cycle t → oWriteEnable = 1 at t+1 only, with address and data valid in the same cycle.
  - The loader can accept the next byte at t+1 (full throughput of 1 byte/cycle).
- Checksum accepted at t:
  - Match → oDone = 1 at t+1; oCpuReset, oBusy = 0 at t+2.
  - Mismatch → oError = 1 at t+1, oBusy = 0 at t+1, oDone never asserted.
- Error from a bad nibble or oversize count → ready drops in the cycle after the offending byte.
- Reset asserted mid-session:
  - All outputs clear asynchronously, including oCpuReset.
  - Instruction RAM contents already written are not restored.
- oWriteAddress wraps modulo 2^ADDR_WIDTH. This is unreachable while MAX_WORDS ≤ 2^ADDR_WIDTH.

## Test plan
- Reset → every output 0, oByteReady = 0 with iByteValid held high, no write.
- iStart, then back-to-back bytes 00 02 0A 12 34 56 01 02 03 04 7C →
  - Write addr 0 = 28'hA123456 and addr 1 = 28'h1020304, one cycle after their 4th bytes.
  - oDone pulse, oWordCount = 2, oCpuReset high from start until 2 cycles after the checksum.
- Same stream with checksum 7D → both writes occur, oError = 1, oDone never set, oCpuReset stays 1. A subsequent good session clears oError and releases oCpuReset.
- Stream 00 01 1A 12 34 56 → error after byte 1A, no write, oByteReady = 0 next cycle; 12 34 56 are not consumed.
- Stream 00 00 00 → oDone, no writes. Stream 01 01 (N = 257 > 256) → oError after the second byte.
- Good 2-word stream with random 0–5 cycle iByteValid gaps; iStart pulsed mid-session (ignored); then Reset asserted after 5 bytes of a new session → all outputs 0 immediately, and the next iStart loads correctly from addr 0.
